// File: rtl/jump_game_fsm_if.sv
// Block-placement interface between the jump game FSM and the block placer.
// Signals:
//   state       - 3-bit game state, driven by the FSM
//   random      - 7-bit pseudo-random value, driven by the FSM
//   x_block1    - x of the current (standing) block, driven by the placer
//   x_block2    - x of the target block, driven by the placer
//   en_block2   - target block valid, driven by the placer
//   reload_done - placer finished repositioning (pulse or level)
// Modports: master = FSM side, slave = block placer side.
interface jump_game_fsm_if;
    logic [2:0]  state;
    logic [6:0]  random;
    logic [31:0] x_block1;
    logic [31:0] x_block2;
    logic        en_block2;
    logic        reload_done;

    modport master (
        output state, random,
        input  x_block1, x_block2, en_block2, reload_done
    );

    modport slave (
        input  state, random,
        output x_block1, x_block2, en_block2, reload_done
    );
endinterface

// File: rtl/jump_game_fsm.sv
// Master game state machine for the jump game.
// Times the key charge, moves the player, judges the landing and drives the
// block placer through jump_game_fsm_if (master modport).
// Ports:
//   clk_machine - system clock
//   rst_machine - synchronous active-high reset
//   key         - debounced jump key, level, 1 = pressed
//   blk         - block placer interface (state/random out; blocks/handshake in)
//   x_player    - player x position
//   score       - landed-jump count (saturating)
//   game_over   - high while in OVER
// Optional feature macro: PERFECT_BONUS_EN (centre landing scores 2).
module jump_game_fsm #(
    parameter int unsigned TICK_DIV   = 100000,
    parameter int unsigned CHARGE_MAX = 63,
    parameter int unsigned DIST_STEP  = 4,
    parameter int unsigned MOVE_STEP  = 2,
    parameter int unsigned HALF_W     = 20,
    parameter int unsigned CENTER_W   = 3
) (
    input  logic                   clk_machine,
    input  logic                   rst_machine,
    input  logic                   key,
    jump_game_fsm_if.master        blk,
    output logic [31:0]            x_player,
    output logic [15:0]            score,
    output logic                   game_over
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RELOAD = 3'd1,
        READY  = 3'd2,
        CHARGE = 3'd3,
        JUMP   = 3'd4,
        JUDGE  = 3'd5,
        OVER   = 3'd6
    } state_t;

    localparam logic [31:0] DIV_LAST = 32'(TICK_DIV - 1);
    localparam logic [31:0] CMAX     = 32'(CHARGE_MAX);
    localparam logic [31:0] DSTEP    = 32'(DIST_STEP);
    localparam logic [31:0] MSTEP    = 32'(MOVE_STEP);
    localparam logic [31:0] HALF_L   = 32'(HALF_W);
    localparam logic [31:0] CENTER_L = 32'(CENTER_W);

`ifdef PERFECT_BONUS_EN
    localparam logic BONUS_EN = 1'b1;
`else
    localparam logic BONUS_EN = 1'b0;
`endif

    state_t      state_q, state_d;
    logic [6:0]  lfsr_q;
    logic [31:0] div_q;
    logic        key_d;
    logic [31:0] x_q, x_d;
    logic [15:0] score_q, score_d;
    logic [31:0] charge_q, charge_d;
    logic [31:0] dist_q, dist_d;
    logic [31:0] travel_q, travel_d;

    logic        tick;
    logic        key_rise;
    logic [31:0] remain, step;
    logic        hit2, hit1, bonus;
    logic [31:0] centre_diff;
    logic [16:0] score_sum;

    function automatic logic [31:0] win_lo(input logic [31:0] x);
        return (x >= HALF_L) ? (x - HALF_L) : '0;
    endfunction

    function automatic logic [31:0] win_hi(input logic [31:0] x);
        return x + HALF_L;
    endfunction

    assign tick     = (div_q == DIV_LAST);
    assign key_rise = key & ~key_d;

    assign blk.state  = state_q;
    assign blk.random = lfsr_q;
    assign x_player   = x_q;
    assign score      = score_q;
    assign game_over  = (state_q == OVER);

    // Landing window tests and score increment; the centre check is always
    // computed and gated by BONUS_EN so the default build ignores it.
    always_comb begin
        remain      = dist_q - travel_q;
        step        = (remain < MSTEP) ? remain : MSTEP;
        hit2        = blk.en_block2 && (x_q >= win_lo(blk.x_block2)) &&
                      (x_q <= win_hi(blk.x_block2));
        hit1        = (x_q >= win_lo(blk.x_block1)) && (x_q <= win_hi(blk.x_block1));
        centre_diff = (x_q >= blk.x_block2) ? (x_q - blk.x_block2) : (blk.x_block2 - x_q);
        bonus       = BONUS_EN && (centre_diff <= CENTER_L);
        score_sum   = {1'b0, score_q} + (bonus ? 17'd2 : 17'd1);
    end

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        score_d  = score_q;
        charge_d = charge_q;
        dist_d   = dist_q;
        travel_d = travel_q;
        case (state_q)
            IDLE: begin
                if (key_rise) begin
                    score_d = '0;
                    state_d = RELOAD;
                end
            end
            RELOAD: begin
                if (blk.reload_done) begin
                    x_d     = blk.x_block1;
                    state_d = READY;
                end
            end
            READY: begin
                if (key_rise) begin
                    charge_d = '0;
                    state_d  = CHARGE;
                end
            end
            CHARGE: begin
                // Release takes priority over a coincident tick.
                if (!key) begin
                    dist_d   = charge_q * DSTEP;
                    travel_d = '0;
                    state_d  = JUMP;
                end else if (tick && (charge_q < CMAX)) begin
                    charge_d = charge_q + 32'd1;
                end
            end
            JUMP: begin
                if (travel_q == dist_q) begin
                    state_d = JUDGE;
                end else if (tick) begin
                    x_d      = x_q + step;
                    travel_d = travel_q + step;
                end
            end
            JUDGE: begin
                if (hit2) begin
                    score_d = score_sum[16] ? 16'hFFFF : score_sum[15:0];
                    state_d = RELOAD;
                end else if (hit1) begin
                    state_d = READY;
                end else begin
                    state_d = OVER;
                end
            end
            OVER: begin
                if (key_rise) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_machine) begin
        if (rst_machine) begin
            state_q  <= IDLE;
            lfsr_q   <= 7'h01;
            div_q    <= '0;
            key_d    <= 1'b0;
            x_q      <= '0;
            score_q  <= '0;
            charge_q <= '0;
            dist_q   <= '0;
            travel_q <= '0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
            div_q    <= tick ? '0 : (div_q + 32'd1);
            key_d    <= key;
            x_q      <= x_d;
            score_q  <= score_d;
            charge_q <= charge_d;
            dist_q   <= dist_d;
            travel_q <= travel_d;
        end
    end
endmodule

// File: tb/tb_jump_game_fsm.sv
module tb_jump_game_fsm;
    logic        clk_machine = 1'b0;
    logic        rst_machine;
    logic        key;
    logic [31:0] x_player;
    logic [15:0] score;
    logic        game_over;
    int          checks = 0;
    int          errors = 0;

    jump_game_fsm_if bus ();

    jump_game_fsm #(
        .TICK_DIV  (1),
        .CHARGE_MAX(63),
        .DIST_STEP (4),
        .MOVE_STEP (2),
        .HALF_W    (20),
        .CENTER_W  (3)
    ) dut (
        .clk_machine(clk_machine),
        .rst_machine(rst_machine),
        .key        (key),
        .blk        (bus),
        .x_player   (x_player),
        .score      (score),
        .game_over  (game_over)
    );

    always #5 clk_machine = ~clk_machine;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk_machine);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_state(input string tag, input logic [2:0] exp, input int budget);
        int n = 0;
        while (bus.state !== exp && n < budget) begin
            step(1);
            n++;
        end
        chk(tag, 32'(bus.state), 32'(exp));
    endtask

    task automatic key_pulse();
        key = 1'b1;
        step(1);
        key = 1'b0;
        step(1);
    endtask

    task automatic reload(input logic [31:0] b1, input logic [31:0] b2, input logic en,
                          input logic [31:0] exp_x);
        bus.x_block1    = b1;
        bus.x_block2    = b2;
        bus.en_block2   = en;
        bus.reload_done = 1'b1;
        step(1);
        bus.reload_done = 1'b0;
        chk("reload_state", 32'(bus.state), 32'd2);
        chk("reload_x", x_player, exp_x);
    endtask

    // Press, hold for n charge cycles, release.
    task automatic charge(input int n);
        key = 1'b1;
        step(1);
        chk("charge_state", 32'(bus.state), 32'd3);
        step(n);
        key = 1'b0;
        step(1);
        chk("jump_state", 32'(bus.state), 32'd4);
    endtask

    initial begin
        rst_machine     = 1'b1;
        key             = 1'b0;
        bus.x_block1    = '0;
        bus.x_block2    = '0;
        bus.en_block2   = 1'b0;
        bus.reload_done = 1'b0;
        step(2);
        chk("rst_state", 32'(bus.state), 32'd0);
        chk("rst_random", 32'(bus.random), 32'h01);
        chk("rst_x", x_player, 32'd0);
        chk("rst_score", 32'(score), 32'd0);
        chk("rst_over", 32'(game_over), 32'd0);
        rst_machine = 1'b0;

        // Start and handshake
        key = 1'b1;
        step(1);
        key = 1'b0;
        chk("start_reload", 32'(bus.state), 32'd1);
        step(10);
        chk("reload_hold", 32'(bus.state), 32'd1);
        reload(32'd100, 32'd200, 1'b1, 32'd100);

        // Good jump: charge 25 -> dist 100 -> lands on 200
        charge(25);
        wait_state("good_judge", 3'd5, 200);
        chk("good_x", x_player, 32'd200);
        step(1);
        chk("good_state", 32'(bus.state), 32'd1);
        chk("good_score", 32'(score), 32'd1);

        // Short jump: charge 2 -> dist 8 -> 208 stays on block1 at 200
        reload(32'd200, 32'd300, 1'b1, 32'd200);
        charge(2);
        wait_state("short_judge", 3'd5, 50);
        chk("short_x", x_player, 32'd208);
        step(1);
        chk("short_state", 32'(bus.state), 32'd2);
        chk("short_score", 32'(score), 32'd1);

        // Reset mid-jump
        charge(10);
        step(5);
        chk("mid_jump", 32'(bus.state), 32'd4);
        rst_machine = 1'b1;
        step(1);
        rst_machine = 1'b0;
        chk("mrst_state", 32'(bus.state), 32'd0);
        chk("mrst_x", x_player, 32'd0);
        chk("mrst_score", 32'(score), 32'd0);
        chk("mrst_random", 32'(bus.random), 32'h01);
        step(1);
        chk("lfsr_first", 32'(bus.random), 32'h02);
        step(126);
        chk("lfsr_period", 32'(bus.random), 32'h01);

        // Game 2: upper window edge counts as a hit
        key_pulse();
        chk("g2_reload", 32'(bus.state), 32'd1);
        reload(32'd100, 32'd200, 1'b1, 32'd100);
        charge(30);
        wait_state("edge_judge", 3'd5, 200);
        chk("edge_x", x_player, 32'd220);
        step(1);
        chk("edge_state", 32'(bus.state), 32'd1);
        chk("edge_score", 32'(score), 32'd1);

        // Target disabled: 252 lies in block2 window but en_block2=0 -> OVER
        reload(32'd220, 32'd260, 1'b0, 32'd220);
        charge(8);
        wait_state("dis_judge", 3'd5, 100);
        chk("dis_x", x_player, 32'd252);
        step(1);
        chk("dis_state", 32'(bus.state), 32'd6);
        chk("dis_over", 32'(game_over), 32'd1);
        chk("dis_score", 32'(score), 32'd1);

        // OVER -> IDLE keeps score; next start clears it
        key_pulse();
        chk("over_idle", 32'(bus.state), 32'd0);
        chk("idle_score_kept", 32'(score), 32'd1);
        chk("idle_over_low", 32'(game_over), 32'd0);
        key_pulse();
        chk("g3_reload", 32'(bus.state), 32'd1);
        chk("g3_score_clear", 32'(score), 32'd0);

        // Saturated charge: 200 cycles -> 63 -> dist 252 -> 352, a miss
        reload(32'd100, 32'd200, 1'b1, 32'd100);
        charge(200);
        wait_state("sat_judge", 3'd5, 400);
        chk("sat_x", x_player, 32'd352);
        step(1);
        chk("sat_state", 32'(bus.state), 32'd6);
        chk("sat_over", 32'(game_over), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
